// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the program counter at the far end of the condition-code
// FSM branch interface. Evaluate and PC-update cycles alternate, so the PC is
// never written in the cycle where the branch decision is being formed. One
// instruction retires every two clocks. Halt/resume support single-stepping.
module pc_sequencer #(
  parameter int                     PC_WIDTH     = 8,
  parameter int                     OFFSET_WIDTH = 6,
  parameter logic [PC_WIDTH-1:0]    RESET_VECTOR = '0
) (
  input  logic                    clka,
  input  logic                    reset_in,
  input  logic                    br_taken_in,
  input  logic [OFFSET_WIDTH-1:0] offset_in,
  input  logic                    jmp_in,
  input  logic [PC_WIDTH-1:0]     jmp_target_in,
  input  logic                    halt_in,
  input  logic                    resume_in,
  output logic [PC_WIDTH-1:0]     pc_out,
  output logic                    phase_out,
  output logic                    pc_we_out,
  output logic [1:0]              state_out
);

  // State encoding is exported directly on state_out.
  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_EVAL   = 2'b01,
    S_UPDATE = 2'b10,
    S_HALT   = 2'b11
  } state_t;

  state_t                  r_state;
  state_t                  w_next_state;

  logic [PC_WIDTH-1:0]     r_pc;
  logic                    r_br_taken;
  logic [OFFSET_WIDTH-1:0] r_offset;
  logic                    r_jmp;
  logic [PC_WIDTH-1:0]     r_jmp_target;

  logic [PC_WIDTH-1:0]     w_offset_ext;
  logic [PC_WIDTH-1:0]     w_pc_next;

  // State register; reset overrides every state, including a pending UPDATE.
  always_ff @(posedge clka) begin
    if (reset_in) r_state <= S_IDLE;
    else          r_state <= w_next_state;
  end

  // Next-state logic. halt_in only matters in EVAL; while halted only
  // resume_in can move the sequencer.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   w_next_state = S_EVAL;
      S_EVAL:   w_next_state = halt_in ? S_HALT : S_UPDATE;
      S_UPDATE: w_next_state = S_EVAL;
      S_HALT:   w_next_state = resume_in ? S_EVAL : S_HALT;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // Capture the branch/jump decision at the end of EVAL. A halt discards it
  // so nothing stale can leak into a later UPDATE.
  always_ff @(posedge clka) begin
    if (reset_in) begin
      r_br_taken   <= 1'b0;
      r_offset     <= '0;
      r_jmp        <= 1'b0;
      r_jmp_target <= '0;
    end else if (r_state == S_EVAL) begin
      if (halt_in) begin
        r_br_taken   <= 1'b0;
        r_offset     <= '0;
        r_jmp        <= 1'b0;
        r_jmp_target <= '0;
      end else begin
        r_br_taken   <= br_taken_in;
        r_offset     <= offset_in;
        r_jmp        <= jmp_in;
        r_jmp_target <= jmp_target_in;
      end
    end
  end

  // Sign-extend the offset to PC width; sizing a signed value extends its MSB.
  assign w_offset_ext = PC_WIDTH'($signed(r_offset));

  // Next PC from the sampled values only: jump beats branch beats increment.
  // Additions wrap modulo 2^PC_WIDTH.
  always_comb begin
    w_pc_next = r_pc + PC_WIDTH'(1);
    if (r_jmp)           w_pc_next = r_jmp_target;
    else if (r_br_taken) w_pc_next = r_pc + w_offset_ext;
  end

  // PC register; written only on the edge that ends UPDATE.
  always_ff @(posedge clka) begin
    if (reset_in)                r_pc <= RESET_VECTOR;
    else if (r_state == S_UPDATE) r_pc <= w_pc_next;
  end

  assign pc_out    = r_pc;
  assign phase_out = (r_state == S_UPDATE);
  assign pc_we_out = (r_state == S_UPDATE);
  assign state_out = r_state;

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter sequencer at the far end of the ALU/condition-code FSM's branch interface.
- Consumes the branch-taken decision (the FSM's pc_ctl_0_out) plus a decoded offset or jump target, and owns the PC register.
- Alternates FSM-evaluation cycles and PC-update cycles so the PC never changes in the cycle where the branch decision is formed.
- Supports halt/resume for single-stepping from the debug controller.

Parameters:
- PC_WIDTH, 8, PC register width in bits.
- OFFSET_WIDTH, 6, width of the two's-complement branch offset.
- RESET_VECTOR, 0, PC value loaded on reset.

Ports:
- clka  input  1  single system clock; all state updates on its rising edge.
- reset_in  input  1  synchronous, active-high reset.
- br_taken_in  input  1  branch decision from the condition-code FSM (pc_ctl_0_out).
- offset_in  input  OFFSET_WIDTH  signed PC-relative branch offset.
- jmp_in  input  1  unconditional absolute jump request.
- jmp_target_in  input  PC_WIDTH  absolute jump target.
- halt_in  input  1  halt request from the decoder or debug controller.
- resume_in  input  1  leave HALT.
- pc_out  output  PC_WIDTH  current PC (registered).
- phase_out  output  1  0 = FSM/evaluate cycle, 1 = PC-update cycle.
- pc_we_out  output  1  high during the cycle whose ending edge writes the PC.
- state_out  output  2  IDLE=00, EVAL=01, UPDATE=10, HALT=11.

Behaviour:
- Interface: single clock clka. Reset reset_in is synchronous and active-high, sampled only on the rising edge of clka.
- Reset, and every cycle reset_in is high:
  - state=IDLE, pc_out=RESET_VECTOR, phase_out=0, pc_we_out=0.
  - All sampled-input registers cleared.
  - Reset wins over every other input in every state, including mid-UPDATE; the pending update is discarded.
- IDLE:
  - phase_out=0, pc_we_out=0.
  - Moves to EVAL on the first edge with reset_in=0.
- EVAL:
  - phase_out=0, pc_we_out=0.
  - On the ending edge, registers br_taken_in, offset_in, jmp_in, jmp_target_in.
  - If halt_in=1: go to HALT; the sampled branch/jump values are discarded and the PC is unchanged.
  - Otherwise go to UPDATE.
- UPDATE:
  - phase_out=1, pc_we_out=1 (combinational from state).
  - All inputs except reset_in are ignored; only the values sampled in EVAL are used.
  - On the ending edge, the PC is written with priority jmp > branch > increment:
    - sampled jmp=1: pc = jmp_target.
    - else sampled br_taken=1: pc = pc + sign_extend(offset).
    - else: pc = pc + 1.
  - Next state is always EVAL.
- HALT:
  - phase_out=0, pc_we_out=0, PC held.
  - resume_in=1: go to EVAL on the next edge; otherwise stay in HALT.
  - halt_in is ignored while in HALT.
- Arithmetic:
  - All PC arithmetic is modulo 2^PC_WIDTH with silent wrap.
  - Offset is sign-extended from OFFSET_WIDTH to PC_WIDTH before the add.
- Latency: inputs sampled at the end of EVAL appear on pc_out one cycle later, i.e. at the end of UPDATE. One instruction per two clocks.
- pc_out is glitch-free; it changes only on the edge that ends UPDATE or on reset.

Test Plan:
Defaults PC_WIDTH=8, OFFSET_WIDTH=6, RESET_VECTOR=0.
1. Reset and sequential fetch: hold reset_in=1 for 2 cycles → state_out=00, pc_out=0x00, phase_out=0 in both. Release with no branch → sequence IDLE, EVAL, UPDATE (phase_out=1, pc_we_out=1); pc_out=0x01 after UPDATE, 0x02 after the next UPDATE.
2. Branch offsets: at pc=0x01, br_taken_in=1 with offset_in=6'h05 in EVAL → pc_out=0x06. Then offset_in=6'h3E (-2) → pc_out=0x04.
3. Jump priority and UPDATE-cycle masking:
   - jmp_in=1, jmp_target_in=0xF0, br_taken_in=1, offset_in=6'h05 → pc_out=0xF0.
   - Toggling br_taken_in only during UPDATE → ignored, pc+1.
4. Wrap-around:
   - pc=0xFF, no branch → pc_out=0x00.
   - pc=0x02, offset_in=6'h3C (-4) → pc_out=0xFE.
   - pc=0xFE, offset_in=6'h1F (+31) → pc_out=0x1D.
5. Halt and resume: halt_in=1 in EVAL with br_taken_in=1 → state_out=11; pc_out unchanged and pc_we_out=0 for 3 cycles; halt_in ignored while in HALT. resume_in=1 → EVAL next cycle; the discarded branch is not applied.
6. Reset mid-operation: reset_in=1 during UPDATE with a pending branch at pc=0x40 → next cycle pc_out=0x00, state_out=00. Also reset_in=1 while in HALT → IDLE.
